// File: rtl/pwm_seq_pkg.sv
// Purpose : shared types and helpers for the multi-channel PWM fade sequencer.
// Latency : n/a (declarations only).
// Backpr. : n/a.
//
// Contents: waveform mode enumeration, four-phase position encodings and the
// elaboration-time channel offset reduction.
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        MODE_FOURPHASE = 2'd0,
        MODE_SAW       = 2'd1,
        MODE_TRI       = 2'd2,
        MODE_STATIC    = 2'd3
    } mode_e;

    // Upper two bits of a channel position: which quarter of the cycle it is in.
    localparam logic [1:0] PHASE_LOW  = 2'd0;
    localparam logic [1:0] PHASE_RISE = 2'd1;
    localparam logic [1:0] PHASE_HIGH = 2'd2;
    localparam logic [1:0] PHASE_FALL = 2'd3;

    // Position offset of channel k, reduced into one full cycle (4 * 2^width).
    // The spread is reduced before multiplying so large SPREAD values cannot overflow.
    function automatic int chan_offset(input int k, input int spread, input int width);
        int span;
        span = 4 * (1 << width);
        return (k * (spread % span)) % span;
    endfunction

endpackage

// File: rtl/pwm_seq_shaper.sv
// Purpose : maps one channel position and waveform mode to a PWM compare value.
// Latency : combinational; with PWM_SEQ_GAMMA_EN one registered stage loaded by i_load.
// Backpr. : none; the value is consumed whenever the top issues a load.
//
// Ports   : i_pos   channel position, [WIDTH+1:WIDTH] = phase, [WIDTH-1:0] = ramp
//           i_mode  waveform mode (mode_e encoding)
//           i_level static level used by MODE_STATIC
//           o_value compare value, 0..2^WIDTH
//           i_clk/i_rst_n/i_load exist only when PWM_SEQ_GAMMA_EN is defined
// Option  : PWM_SEQ_GAMMA_EN squares the value ((v*v)>>WIDTH) except in MODE_STATIC.
module pwm_seq_shaper
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
`ifdef PWM_SEQ_GAMMA_EN
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
`endif
    input  logic [WIDTH+1:0] i_pos,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH:0]   i_level,
    output logic [WIDTH:0]   o_value
);

    localparam logic [WIDTH:0] FULL_V = {1'b1, {WIDTH{1'b0}}};

    logic [1:0]       phase;
    logic [WIDTH-1:0] ramp;
    logic [WIDTH:0]   ramp_v;
    logic [WIDTH:0]   fall_v;
    logic [WIDTH:0]   lin_v;

    assign phase  = i_pos[WIDTH+1:WIDTH];
    assign ramp   = i_pos[WIDTH-1:0];
    assign ramp_v = {1'b0, ramp};
    // One bit wider than the ramp so that ramp 0 on a falling edge gives FULL, not 0.
    assign fall_v = FULL_V - ramp_v;

    always_comb begin
        lin_v = ramp_v;
        case (i_mode)
            MODE_FOURPHASE: begin
                case (phase)
                    PHASE_LOW:  lin_v = '0;
                    PHASE_RISE: lin_v = ramp_v;
                    PHASE_HIGH: lin_v = FULL_V;
                    default:    lin_v = fall_v;
                endcase
            end
            MODE_SAW: lin_v = ramp_v;
            // phase[0] is position bit WIDTH: odd half-periods fall.
            MODE_TRI: lin_v = phase[0] ? fall_v : ramp_v;
            default:  lin_v = i_level;
        endcase
    end

`ifdef PWM_SEQ_GAMMA_EN
    logic [WIDTH:0]     lin_q, lin_d;
    logic               bypass_q, bypass_d;
    logic [2*WIDTH+1:0] lin_ext;
    logic [2*WIDTH+1:0] square;
    logic               unused_square_bits;

    always_comb begin
        lin_d    = lin_q;
        bypass_d = bypass_q;
        if (i_load) begin
            lin_d    = lin_v;
            bypass_d = (i_mode == MODE_STATIC);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lin_q    <= '0;
            bypass_q <= 1'b0;
        end else begin
            lin_q    <= lin_d;
            bypass_q <= bypass_d;
        end
    end

    // FULL*FULL >> WIDTH == FULL, so the top end of the range is preserved exactly.
    assign lin_ext = {{(WIDTH+1){1'b0}}, lin_q};
    assign square  = lin_ext * lin_ext;
    assign o_value = bypass_q ? lin_q : square[2*WIDTH:WIDTH];
    assign unused_square_bits = ^{square[2*WIDTH+1], square[WIDTH-1:0]};
`else
    assign o_value = lin_v;
`endif

endmodule

// File: rtl/pwm_sequencer_multi.sv
// Purpose : multi-channel PWM fade sequencer; one shared step timer/position, per-channel phase spread.
// Latency : tick/sync/post-reset load -> o_compare + valid pulse 1 cycle (2 with PWM_SEQ_GAMMA_EN).
// Backpr. : none; each load is a one-cycle valid pulse the PWM bank must accept.
//
// Ports   : i_enable advances the timer, i_sync restarts timer and position,
//           i_mode latched at tick/sync, i_level static level for mode 3,
//           o_top constant FULL-1, o_compare channel k at [k*(WIDTH+1) +: WIDTH+1],
//           o_compare_valid / o_top_valid one-cycle load pulse.
// Option  : PWM_SEQ_GAMMA_EN adds a squaring gamma stage and one cycle of latency.
module pwm_sequencer_multi
    import pwm_seq_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int STEP     = 97_276,
    parameter int SPREAD   = 256
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_enable,
    input  logic                            i_sync,
    input  logic [1:0]                      i_mode,
    input  logic [WIDTH:0]                  i_level,
    output logic [WIDTH-1:0]                o_top,
    output logic                            o_top_valid,
    output logic [CHANNELS*(WIDTH+1)-1:0]   o_compare,
    output logic                            o_compare_valid
);

    localparam int CMP_W = WIDTH + 1;
    localparam int POS_W = WIDTH + 2;
    localparam int CNT_W = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP - 1);

    logic [CNT_W-1:0]          step_cnt_q, step_cnt_d;
    logic [POS_W-1:0]          pos_q, pos_d;
    logic [1:0]                mode_q, mode_d;
    logic                      started_q, started_d;
    logic                      load_q, load_d;
    logic [CHANNELS*CMP_W-1:0] compare_q, compare_d;
    logic [CHANNELS*CMP_W-1:0] shaped_all;
    logic                      tick;

    assign tick = i_enable && (step_cnt_q == CNT_LAST);

    // Timer and position. Sync wins over tick, so a coincident pair restarts at 0.
    // The first cycle out of reset issues one load so the PWM bank gets initial values.
    always_comb begin
        step_cnt_d = step_cnt_q;
        pos_d      = pos_q;
        mode_d     = mode_q;
        started_d  = 1'b1;
        load_d     = !started_q;
        if (i_sync) begin
            step_cnt_d = '0;
            pos_d      = '0;
            mode_d     = i_mode;
            load_d     = 1'b1;
        end else if (tick) begin
            step_cnt_d = '0;
            pos_d      = pos_q + POS_W'(1);   // natural wrap at 4*FULL
            mode_d     = i_mode;
            load_d     = 1'b1;
        end else if (i_enable) begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
        end
    end

    // Shapers see the post-update position/mode so the output register can
    // capture the new values on the same edge that raises load.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        localparam logic [POS_W-1:0] OFFSET = POS_W'(chan_offset(k, SPREAD, WIDTH));
        logic [POS_W-1:0] chan_pos;

        assign chan_pos = pos_d + OFFSET;

        pwm_seq_shaper #(
            .WIDTH   (WIDTH)
        ) u_shaper (
`ifdef PWM_SEQ_GAMMA_EN
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_load  (load_d),
`endif
            .i_pos   (chan_pos),
            .i_mode  (mode_d),
            .i_level (i_level),
            .o_value (shaped_all[k*CMP_W +: CMP_W])
        );
    end

`ifdef PWM_SEQ_GAMMA_EN
    // The shapers hold the linear value for one cycle; load_q marks it ready.
    logic valid_q, valid_d;

    always_comb begin
        compare_d = compare_q;
        valid_d   = load_q;
        if (load_q) begin
            compare_d = shaped_all;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign o_compare_valid = valid_q;
`else
    always_comb begin
        compare_d = compare_q;
        if (load_d) begin
            compare_d = shaped_all;
        end
    end

    assign o_compare_valid = load_q;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_cnt_q <= '0;
            pos_q      <= '0;
            mode_q     <= '0;
            started_q  <= 1'b0;
            load_q     <= 1'b0;
            compare_q  <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
            pos_q      <= pos_d;
            mode_q     <= mode_d;
            started_q  <= started_d;
            load_q     <= load_d;
            compare_q  <= compare_d;
        end
    end

    assign o_compare   = compare_q;
    assign o_top       = {WIDTH{1'b1}};
    assign o_top_valid = o_compare_valid;

endmodule

// File: tb/tb_pwm_sequencer_multi.sv
`timescale 1ns/1ps
module tb_pwm_sequencer_multi;

    localparam int CHANNELS = 2;
    localparam int WIDTH    = 4;
    localparam int STEP     = 3;
    localparam int SPREAD   = 16;
    localparam int FULL     = 1 << WIDTH;
    localparam int SPAN     = 4 * FULL;
    localparam int CW       = WIDTH + 1;
`ifdef PWM_SEQ_GAMMA_EN
    localparam bit GAMMA_ON = 1'b1;
    localparam int LAT      = 2;
`else
    localparam bit GAMMA_ON = 1'b0;
    localparam int LAT      = 1;
`endif

    logic                        i_clk    = 1'b0;
    logic                        i_rst_n  = 1'b0;
    logic                        i_enable = 1'b0;
    logic                        i_sync   = 1'b0;
    logic [1:0]                  i_mode   = 2'd0;
    logic [WIDTH:0]              i_level  = '0;
    logic [WIDTH-1:0]            o_top;
    logic                        o_top_valid;
    logic [CHANNELS*CW-1:0]      o_compare;
    logic                        o_compare_valid;

    pwm_sequencer_multi #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .SPREAD   (SPREAD)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_enable        (i_enable),
        .i_sync          (i_sync),
        .i_mode          (i_mode),
        .i_level         (i_level),
        .o_top           (o_top),
        .o_top_valid     (o_top_valid),
        .o_compare       (o_compare),
        .o_compare_valid (o_compare_valid)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ch(input int k);
        return int'(o_compare[k*CW +: CW]);
    endfunction

    // Literal expectation for linear and gamma builds.
    function automatic int lit(input int lin, input int gam);
        return GAMMA_ON ? gam : lin;
    endfunction

    // ---------------- behavioural model ----------------
    function automatic int wave(input int mode, input int p, input int lvl);
        int quarter;
        int r;
        quarter = p / FULL;
        r       = p % FULL;
        case (mode)
            0: begin
                if (quarter == 0)      return 0;
                else if (quarter == 1) return r;
                else if (quarter == 2) return FULL;
                else                   return FULL - r;
            end
            1:       return r;
            2:       return ((quarter % 2) == 0) ? r : FULL - r;
            default: return lvl;
        endcase
    endfunction

    function automatic int shape(input int mode, input int p, input int lvl);
        int v;
        v = wave(mode, p, lvl);
        if (GAMMA_ON && mode != 3) v = (v * v) / FULL;
        return v;
    endfunction

    int m_pos = 0, m_cnt = 0, m_mode = 0;
    bit m_started = 1'b0;
    bit exp_vld = 1'b0;
    int exp_ch[CHANNELS] = '{default: 0};
    bit pend_vld = 1'b0;
    int pend_ch[CHANNELS] = '{default: 0};
    bit s_en, s_sy, s_load;
    int s_md, s_lv;

    always begin
        @(posedge i_clk);
        s_en = i_enable;
        s_sy = i_sync;
        s_md = int'(i_mode);
        s_lv = int'(i_level);
        if (!i_rst_n) begin
            m_pos = 0; m_cnt = 0; m_mode = 0; m_started = 1'b0;
            exp_vld = 1'b0; pend_vld = 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                exp_ch[k] = 0; pend_ch[k] = 0;
            end
        end else begin
            s_load = !m_started;
            m_started = 1'b1;
            if (s_sy) begin
                m_cnt = 0; m_pos = 0; m_mode = s_md; s_load = 1'b1;
            end else if (s_en && m_cnt == STEP - 1) begin
                m_cnt = 0; m_pos = (m_pos + 1) % SPAN; m_mode = s_md; s_load = 1'b1;
            end else if (s_en) begin
                m_cnt = m_cnt + 1;
            end
            if (GAMMA_ON) begin
                exp_vld = pend_vld;
                if (pend_vld) for (int k = 0; k < CHANNELS; k++) exp_ch[k] = pend_ch[k];
                pend_vld = s_load;
                if (s_load) for (int k = 0; k < CHANNELS; k++)
                    pend_ch[k] = shape(m_mode, (m_pos + k * SPREAD) % SPAN, s_lv);
            end else begin
                exp_vld = s_load;
                if (s_load) for (int k = 0; k < CHANNELS; k++)
                    exp_ch[k] = shape(m_mode, (m_pos + k * SPREAD) % SPAN, s_lv);
            end
        end
        #1;
        chk("cyc_valid", int'(o_compare_valid), int'(exp_vld));
        chk("cyc_top_valid", int'(o_top_valid), int'(exp_vld));
        chk("cyc_top", int'(o_top), FULL - 1);
        for (int k = 0; k < CHANNELS; k++)
            chk($sformatf("cyc_ch%0d", k), ch(k), exp_ch[k]);
    end

    // ---------------- directed stimulus ----------------
    task automatic next_pulse(output int gap);
        gap = 0;
        do begin
            @(posedge i_clk); #2;
            gap++;
        end while (!o_compare_valid && gap < 40);
        chk("pulse_seen", int'(o_compare_valid), 1);
    endtask

    task automatic skip_pulses(input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            next_pulse(g);
            chk("step_gap", g, STEP);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int seen;
        i_rst_n = 1'b0; i_enable = 1'b1; i_sync = 1'b0; i_mode = 2'd0; i_level = '0;
        repeat (3) @(posedge i_clk);
        #2;
        chk("rst_valid", int'(o_compare_valid), 0);
        chk("rst_ch0", ch(0), 0);
        chk("rst_ch1", ch(1), 0);
        chk("rst_top", int'(o_top), 15);

        // Release: initial load, then four-phase mode 0 over a full wrap.
        @(negedge i_clk); i_rst_n = 1'b1;
        next_pulse(g);
        chk("init_lat", g, LAT);
        chk("init_ch0", ch(0), 0);
        chk("init_ch1", ch(1), 0);
        next_pulse(g);
        chk("first_gap", g, 2);
        chk("pos1_ch1", ch(1), lit(1, 0));
        skip_pulses(14);
        chk("pos15_ch0", ch(0), 0);
        chk("pos15_ch1", ch(1), lit(15, 14));
        skip_pulses(1);
        chk("pos16_ch0", ch(0), 0);
        chk("pos16_ch1", ch(1), 16);
        skip_pulses(16);
        chk("pos32_ch0", ch(0), 16);
        chk("pos32_ch1", ch(1), 16);
        skip_pulses(16);
        chk("pos48_ch0", ch(0), 16);
        chk("pos48_ch1", ch(1), 0);
        skip_pulses(15);
        chk("pos63_ch0", ch(0), lit(1, 0));
        chk("pos63_ch1", ch(1), 0);
        skip_pulses(1);
        chk("wrap_ch0", ch(0), 0);
        chk("wrap_ch1", ch(1), 0);

        // Triangle, selected mid-step: no effect until the next load.
        @(negedge i_clk); i_mode = 2'd2;
        @(posedge i_clk); #2;
        chk("midstep_novalid", int'(o_compare_valid), 0);
        chk("midstep_hold_ch1", ch(1), 0);
        next_pulse(g);
        chk("tri_pos1_ch0", ch(0), lit(1, 0));
        chk("tri_pos1_ch1", ch(1), lit(15, 14));
        skip_pulses(15);
        chk("tri_pos16_ch0", ch(0), 16);
        chk("tri_pos16_ch1", ch(1), 0);
        skip_pulses(1);
        chk("tri_pos17_ch0", ch(0), lit(15, 14));
        chk("tri_pos17_ch1", ch(1), lit(1, 0));

        // Freeze for 10 clocks mid-step.
        @(negedge i_clk);
        @(negedge i_clk); i_enable = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge i_clk); #2;
            if (o_compare_valid) seen++;
        end
        chk("freeze_no_valid", seen, 0);
        chk("freeze_hold_ch0", ch(0), lit(15, 14));
        @(negedge i_clk); i_enable = 1'b1;
        next_pulse(g);
        chk("reenable_gap", g, 2);
        chk("tri_pos18_ch0", ch(0), lit(14, 12));

        // Sync on the tick cycle: single restart to position 0.
        repeat (4 - LAT) @(negedge i_clk);
        i_sync = 1'b1;
        next_pulse(g);
        chk("sync_lat", g, LAT);
        chk("sync_ch0", ch(0), 0);
        chk("sync_ch1", ch(1), 16);
        @(negedge i_clk); i_sync = 1'b0;
        next_pulse(g);
        chk("post_sync_gap", g, STEP);
        chk("post_sync_ch0", ch(0), lit(1, 0));
        chk("post_sync_ch1", ch(1), lit(15, 14));

        // Static level, sampled only at load.
        @(negedge i_clk); i_mode = 2'd3; i_level = 5'd9;
        next_pulse(g);
        chk("static_ch0", ch(0), 9);
        chk("static_ch1", ch(1), 9);
        @(negedge i_clk); i_level = 5'd5;
        @(posedge i_clk); #2;
        chk("static_hold", ch(0), 9);
        next_pulse(g);
        chk("static2_ch0", ch(0), 5);
        chk("static2_ch1", ch(1), 5);

        // Sawtooth.
        @(negedge i_clk); i_mode = 2'd1;
        next_pulse(g);
        chk("saw_pos4_ch0", ch(0), lit(4, 1));
        chk("saw_pos4_ch1", ch(1), lit(4, 1));
        skip_pulses(4);
        chk("saw_pos8_ch0", ch(0), lit(8, 4));
        chk("saw_pos8_ch1", ch(1), lit(8, 4));

        // Reset asserted while a pulse is showing clears it immediately.
        next_pulse(g);
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(o_compare_valid), 0);
        chk("arst_top_valid", int'(o_top_valid), 0);
        chk("arst_ch0", ch(0), 0);
        chk("arst_ch1", ch(1), 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk); i_rst_n = 1'b1; i_mode = 2'd0;
        next_pulse(g);
        chk("rerelease_lat", g, LAT);
        chk("rerelease_ch0", ch(0), 0);

        repeat (5) @(posedge i_clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
